// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a five-stage in-order pipeline: load-use interlock,
// EX-stage redirect flush, data-memory wait/timeout FSM and saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             ex_jump,
    input  logic             ex_out_allow,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             id_ready_go,
    output logic             ex_ready_go,
    output logic             mem_ready_go,
    output logic             if_id_clear,
    output logic             id_ex_clear,
    output logic             pc_redirect,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic in_err;
    logic load_use;
    logic redirect;
    logic stall_event;

    // Pipeline interlock and redirect: purely combinational so a hazard
    // holds ID in the very cycle it is detected.
    always_comb begin
        in_err      = (state_q == S_ERR);
        load_use    = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
        ex_ready_go = !in_err;
        id_ready_go = !load_use && !in_err;
        redirect    = ex_valid && (ex_br_taken || ex_jump) && ex_ready_go && ex_out_allow;
        pc_redirect = redirect;
        if_id_clear = redirect;
        id_ex_clear = redirect;
    end

    // Memory-response FSM: the timer counts cycles spent waiting, the RUN cycle
    // that issued the request counting as the first.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mem_ready_go = 1'b0;
        case (state_q)
            S_RUN: begin
                mem_ready_go = !mem_req || mem_ack;
                if (mem_req && !mem_ack) begin
                    state_d = S_MEM_WAIT;
                    timer_d = TMR_ONE;
                end
            end
            S_MEM_WAIT: begin
                mem_ready_go = mem_ack;
                if (mem_ack || !mem_req) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_ERR: begin
                mem_ready_go = 1'b0;
            end
            default: begin
                state_d = S_RUN;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_event = !in_err && ((id_valid && !id_ready_go) || (mem_req && !mem_ready_go));
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            timer_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ERR is left only through reset, so the state itself is the sticky flag.
    assign mem_err   = in_err;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: interlock, redirect,
// memory wait/timeout, counter saturation and reset recovery.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 16;
    localparam int OBS_W = 9 + 2 * CNT_W;
    localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_is_load, ex_br_taken, ex_jump, ex_out_allow;
    logic mem_req, mem_ack;
    logic id_ready_go, ex_ready_go, mem_ready_go;
    logic if_id_clear, id_ex_clear, pc_redirect, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] dbg_state;

    logic [OBS_W-1:0] exp_q[$];
    string            tag_q[$];
    logic [CNT_W-1:0] m_stall, m_flush;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .ex_jump(ex_jump), .ex_out_allow(ex_out_allow),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .id_ready_go(id_ready_go), .ex_ready_go(ex_ready_go), .mem_ready_go(mem_ready_go),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .pc_redirect(pc_redirect),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    task automatic idle_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_br_taken = 0; ex_jump = 0;
        ex_out_allow = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Inputs are already driven (posedge+1); sample at negedge, then advance one cycle.
    task automatic check(input string tag, input logic e_id, input logic e_mem,
                         input logic e_redir, input logic [1:0] e_state);
        logic [OBS_W-1:0] exp_v, obs_v;
        string t;
        exp_v = {e_id, (e_state != S_ERR), e_mem, e_redir, e_redir, e_redir,
                 (e_state == S_ERR), e_state, m_stall, m_flush};
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(negedge clk);
        obs_v = {id_ready_go, ex_ready_go, mem_ready_go, pc_redirect, if_id_clear,
                 id_ex_clear, mem_err, dbg_state, stall_cnt, flush_cnt};
        exp_v = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs_v, exp_v);
        end
        if (!rst_n) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if ((e_state != S_ERR) && ((id_valid && !e_id) || (mem_req && !e_mem)) &&
                (m_stall != {CNT_W{1'b1}}))
                m_stall = m_stall + 1'b1;
            if (e_redir && (m_flush != {CNT_W{1'b1}}))
                m_flush = m_flush + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        check("reset", 1, 1, 0, S_RUN);
        rst_n = 1;
    endtask

    initial begin
        m_stall = '0;
        m_flush = '0;
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        #1;
        check("reset_idle", 1, 1, 0, S_RUN);
        rst_n = 1;
        check("run_idle", 1, 1, 0, S_RUN);

        // Load-use interlock
        id_valid = 1; id_rs2 = 5'd5; id_use_rs2 = 1;
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
        check("lw_rs2_hazard", 0, 1, 0, S_RUN);
        id_rs2 = 5'd0; ex_rd = 5'd0;
        check("lw_rd_x0", 1, 1, 0, S_RUN);
        id_use_rs2 = 0; id_rs1 = 5'd7; ex_rd = 5'd7; id_use_rs1 = 0;
        check("rs1_not_used", 1, 1, 0, S_RUN);
        id_use_rs1 = 1;
        check("lw_rs1_hazard", 0, 1, 0, S_RUN);
        ex_is_load = 0;
        check("alu_no_hazard", 1, 1, 0, S_RUN);
        ex_is_load = 1; ex_valid = 0;
        check("ex_invalid", 1, 1, 0, S_RUN);
        ex_valid = 1; id_valid = 0;
        check("id_invalid", 1, 1, 0, S_RUN);

        // Redirect, alone and together with a load-use hazard
        id_valid = 1; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 5'd9; ex_rd = 5'd9;
        ex_br_taken = 1; ex_out_allow = 1;
        check("br_with_hazard", 0, 1, 1, S_RUN);
        ex_out_allow = 0;
        check("br_blocked", 0, 1, 0, S_RUN);
        ex_out_allow = 1; ex_br_taken = 0; ex_jump = 1; ex_is_load = 0;
        check("jump", 1, 1, 1, S_RUN);
        ex_valid = 0;
        check("jump_ex_invalid", 1, 1, 0, S_RUN);
        idle_inputs();

        // Memory response after three cycles
        mem_req = 1;
        check("mem_req_run", 1, 0, 0, S_RUN);
        check("mem_wait_1", 1, 0, 0, S_WAIT);
        check("mem_wait_2", 1, 0, 0, S_WAIT);
        mem_ack = 1;
        check("mem_ack", 1, 1, 0, S_WAIT);
        idle_inputs();
        check("mem_back_run", 1, 1, 0, S_RUN);
        mem_req = 1; mem_ack = 1;
        check("mem_ack_same_cycle", 1, 1, 0, S_RUN);

        // Request withdrawn while waiting
        mem_ack = 0;
        check("wd_req", 1, 0, 0, S_RUN);
        mem_req = 0;
        check("wd_withdrawn", 1, 0, 0, S_WAIT);
        check("wd_back_run", 1, 1, 0, S_RUN);

        // Ack on the last permitted cycle wins over the timeout
        do_reset();
        mem_req = 1;
        for (int i = 0; i < TMO; i++) begin
            if (i == TMO - 1) mem_ack = 1;
            check("late_ack", 1, (i == TMO - 1), 0, (i == 0) ? S_RUN : S_WAIT);
        end
        idle_inputs();
        check("late_ack_run", 1, 1, 0, S_RUN);

        // Stall counter saturation
        do_reset();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd3;
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd3;
        for (int i = 0; i < 20; i++) check("stall_sat", 0, 1, 0, S_RUN);
        idle_inputs();
        check("stall_sat_hold", 1, 1, 0, S_RUN);

        // Timeout into ERR, then reset recovery
        do_reset();
        mem_req = 1;
        for (int i = 0; i < TMO; i++)
            check("timeout_wait", 1, 0, 0, (i == 0) ? S_RUN : S_WAIT);
        id_valid = 1; id_use_rs1 = 0; ex_valid = 1; ex_br_taken = 1; ex_out_allow = 1;
        for (int i = 0; i < 3; i++) check("err_hold", 0, 0, 0, S_ERR);
        mem_ack = 1;
        check("err_ack_ignored", 0, 0, 0, S_ERR);
        idle_inputs();
        rst_n = 0;
        check("err_in_reset", 0, 0, 0, S_ERR);
        rst_n = 1;
        check("after_err_reset", 1, 1, 0, S_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
